// File: rtl/rv_dmem_mmio.sv
// rtl/rv_dmem_mmio.sv - data-side memory responder: byte-writable RAM plus UART TX MMIO window
module rv_dmem_mmio #(
    parameter int RAM_ADDR_W   = 12,
    parameter int FIFO_DEPTH   = 16,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dmem_en,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_d,
    input  logic [3:0]  dmem_we,
    output logic [31:0] dmem_q,
    output logic        uart_tx
);

    localparam int FA_W   = $clog2(FIFO_DEPTH);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam int RAM_WORDS = 1 << RAM_ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_t;

    // Storage
    logic [31:0]     r_ram  [0:RAM_WORDS-1];
    logic [7:0]      r_fifo [0:FIFO_DEPTH-1];

    // Registered state
    logic [31:0]     r_dmem_q;
    logic [FA_W:0]   r_wr_ptr;
    logic [FA_W:0]   r_rd_ptr;
    logic            r_overflow;
    tx_state_t       r_state;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic            r_uart_tx;

    // Decode and control wires
    logic            w_sel_ram;
    logic            w_sel_mmio;
    logic            w_sel_txdata;
    logic            w_sel_status;
    logic            w_is_read;
    logic [RAM_ADDR_W-1:0] w_ram_idx;
    logic            w_fifo_empty;
    logic            w_fifo_full;
    logic            w_push_req;
    logic            w_push;
    logic            w_pop;
    logic            w_ovf_clr;
    logic            w_tx_busy;
    logic [31:0]     w_status;
    logic [31:0]     w_rd_data;
    logic [7:0]      w_fifo_head;
    logic [7:0]      w_shift_next;
    logic            w_unused_addr;

    // Region decode on the top nibble; MMIO registers on word offset
    assign w_sel_ram    = (dmem_addr[31:28] == 4'h0);
    assign w_sel_mmio   = (dmem_addr[31:28] == 4'h1);
    assign w_sel_txdata = w_sel_mmio && (dmem_addr[3:2] == 2'd0);
    assign w_sel_status = w_sel_mmio && (dmem_addr[3:2] == 2'd1);
    assign w_is_read    = dmem_en && (dmem_we == 4'b0000);
    assign w_ram_idx    = dmem_addr[RAM_ADDR_W+1:2];

    // Byte offset and the aliased high address bits carry no meaning here
    assign w_unused_addr = ^dmem_addr;

    // FIFO flags from extended pointers: MSB difference distinguishes full from empty
    assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
    assign w_fifo_full  = (r_wr_ptr[FA_W] != r_rd_ptr[FA_W]) &&
                          (r_wr_ptr[FA_W-1:0] == r_rd_ptr[FA_W-1:0]);
    assign w_fifo_head  = r_fifo[r_rd_ptr[FA_W-1:0]];

    // A push into a full FIFO is dropped even if the serialiser pops that same cycle
    assign w_push_req = dmem_en && w_sel_txdata && dmem_we[0];
    assign w_push     = w_push_req && !w_fifo_full;
    assign w_pop      = (r_state == S_IDLE) && !w_fifo_empty;
    assign w_ovf_clr  = dmem_en && w_sel_status && dmem_we[0] && dmem_d[3];

    assign w_tx_busy  = (r_state != S_IDLE);
    assign w_status   = {28'd0, r_overflow, w_tx_busy, w_fifo_empty, w_fifo_full};

    assign w_shift_next = {1'b0, r_shift[7:1]};

    // Read-data mux; TXDATA and unmapped space read as zero
    always_comb begin
        w_rd_data = 32'd0;
        if (w_sel_ram) begin
            w_rd_data = r_ram[w_ram_idx];
        end else if (w_sel_status) begin
            w_rd_data = w_status;
        end
    end

    // Data RAM with per-byte write enables; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (dmem_en && w_sel_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (dmem_we[i]) begin
                    r_ram[w_ram_idx][8*i +: 8] <= dmem_d[8*i +: 8];
                end
            end
        end
    end

    // Registered read port; holds across writes and idle cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dmem_q <= 32'd0;
        end else if (w_is_read) begin
            r_dmem_q <= w_rd_data;
        end
    end

    // TX FIFO storage
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr[FA_W-1:0]] <= dmem_d[7:0];
        end
    end

    // FIFO pointers; push and pop may both land in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Sticky overflow flag, set on a dropped push, cleared by software
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_push_req && w_fifo_full) begin
            r_overflow <= 1'b1;
        end else if (w_ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    // 8N1 serialiser; the line level is registered so it never glitches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'd0;
            r_uart_tx <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_uart_tx <= 1'b1;
                    r_baud    <= '0;
                    if (w_pop) begin
                        r_shift   <= w_fifo_head;
                        r_uart_tx <= 1'b0;
                        r_state   <= S_START;
                    end
                end
                S_START: begin
                    if (r_baud == BAUD_LAST) begin
                        r_baud    <= '0;
                        r_bit_cnt <= 3'd0;
                        r_uart_tx <= r_shift[0];
                        r_state   <= S_DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_baud == BAUD_LAST) begin
                        r_baud <= '0;
                        if (r_bit_cnt == 3'd7) begin
                            r_uart_tx <= 1'b1;
                            r_state   <= S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_shift   <= w_shift_next;
                            r_uart_tx <= w_shift_next[0];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_baud == BAUD_LAST) begin
                        r_baud  <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_uart_tx <= 1'b1;
                end
            endcase
        end
    end

    assign dmem_q  = r_dmem_q;
    assign uart_tx = r_uart_tx;

endmodule

// File: tb/tb_rv_dmem_mmio.sv
// tb/tb_rv_dmem_mmio.sv - directed self-checking bench for rv_dmem_mmio
module tb_rv_dmem_mmio;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    localparam logic [31:0] A_RAM    = 32'h0000_0100;
    localparam logic [31:0] A_TXDATA = 32'h1000_0000;
    localparam logic [31:0] A_STATUS = 32'h1000_0004;

    logic        clk;
    logic        rst_n;
    logic        dmem_en;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_d;
    logic [3:0]  dmem_we;
    logic [31:0] dmem_q;
    logic        uart_tx;

    int n_checks = 0;
    int n_errors = 0;

    // Line monitor state
    bit         mon_active = 1'b0;
    int         mon_cnt    = 0;
    logic [9:0] mon_bits   = '0;
    int         mon_glitch = 0;
    int         mon_ferr   = 0;
    logic [7:0] rx_q [$];

    rv_dmem_mmio #(
        .RAM_ADDR_W  (12),
        .FIFO_DEPTH  (DEPTH),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .dmem_en  (dmem_en),
        .dmem_addr(dmem_addr),
        .dmem_d   (dmem_d),
        .dmem_we  (dmem_we),
        .dmem_q   (dmem_q),
        .uart_tx  (uart_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decodes 8N1 frames; every bit must hold for exactly CPB samples
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_active <= 1'b0;
            mon_cnt    <= 0;
        end else if (!mon_active) begin
            if (uart_tx === 1'b0) begin
                mon_active  <= 1'b1;
                mon_cnt     <= 1;
                mon_bits[0] <= 1'b0;
            end
        end else begin
            if ((mon_cnt % CPB) == 0) begin
                mon_bits[mon_cnt / CPB] <= uart_tx;
            end else if (uart_tx !== mon_bits[mon_cnt / CPB]) begin
                mon_glitch <= mon_glitch + 1;
            end
            if (mon_cnt == 10 * CPB - 1) begin
                mon_active <= 1'b0;
                rx_q.push_back(mon_bits[8:1]);
                if (mon_bits[9] !== 1'b1) begin
                    mon_ferr <= mon_ferr + 1;
                end
            end else begin
                mon_cnt <= mon_cnt + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
        dmem_en   = 1'b1;
        dmem_addr = a;
        dmem_d    = d;
        dmem_we   = we;
        @(negedge clk);
        dmem_en   = 1'b0;
        dmem_we   = 4'b0000;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] q);
        dmem_en   = 1'b1;
        dmem_addr = a;
        dmem_we   = 4'b0000;
        @(negedge clk);
        dmem_en   = 1'b0;
        q         = dmem_q;
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k;
        k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("rx_count", rx_q.size(), n);
    endtask

    task automatic chk_rx(input string tag, input logic [7:0] exp);
        logic [7:0] b;
        if (rx_q.size() == 0) begin
            chk(tag, 32'hFFFF_FFFF, {24'd0, exp});
        end else begin
            b = rx_q.pop_front();
            chk(tag, {24'd0, b}, {24'd0, exp});
        end
    endtask

    initial begin
        logic [31:0] q;
        logic [7:0]  exp6 [0:5];
        rst_n     = 1'b0;
        dmem_en   = 1'b0;
        dmem_addr = 32'd0;
        dmem_d    = 32'd0;
        dmem_we   = 4'b0000;
        repeat (3) @(negedge clk);
        chk("reset_q", dmem_q, 32'd0);
        chk("reset_tx", {31'd0, uart_tx}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        rd(A_STATUS, q);
        chk("reset_status", q, 32'h2);

        // RAM full-word and byte-lane writes
        wr(A_RAM, 32'hDEAD_BEEF, 4'b1111);
        rd(A_RAM, q);
        chk("ram_word", q, 32'hDEAD_BEEF);
        wr(A_RAM, 32'h00AA_0000, 4'b0100);
        chk("write_keeps_q", dmem_q, 32'hDEAD_BEEF);
        rd(A_RAM, q);
        chk("ram_byte2", q, 32'hDEAA_BEEF);
        repeat (3) @(negedge clk);
        chk("q_holds", dmem_q, 32'hDEAA_BEEF);
        rd(32'h0000_4100, q);
        chk("ram_alias", q, 32'hDEAA_BEEF);

        // Unmapped and write-only reads return zero
        rd(32'h4000_0000, q);
        chk("unmapped_rd", q, 32'd0);
        rd(A_RAM, q);
        rd(32'h1000_000C, q);
        chk("mmio_unmapped_rd", q, 32'd0);
        rd(A_RAM, q);
        rd(A_TXDATA, q);
        chk("txdata_rd", q, 32'd0);

        // Unmapped writes and disabled strobes leave RAM untouched
        wr(32'h4000_0100, 32'hFFFF_FFFF, 4'b1111);
        wr(32'h1000_000C, 32'hFFFF_FFFF, 4'b1111);
        dmem_en   = 1'b0;
        dmem_addr = A_RAM;
        dmem_d    = 32'h0;
        dmem_we   = 4'b1111;
        @(negedge clk);
        dmem_we   = 4'b0000;
        rd(A_RAM, q);
        chk("ram_unchanged", q, 32'hDEAA_BEEF);

        // TXDATA write without lane 0 is ignored
        wr(A_TXDATA, 32'h0000_5500, 4'b1110);
        rd(A_STATUS, q);
        chk("txdata_lane0_only", q, 32'h2);

        // Single byte 0x55 on the line
        rx_q.delete();
        wr(A_TXDATA, 32'h0000_0055, 4'b0001);
        repeat (6) @(negedge clk);
        rd(A_STATUS, q);
        chk("status_busy", q, 32'h6);
        wait_rx(1, 80);
        chk_rx("rx_55", 8'h55);
        repeat (3) @(negedge clk);
        rd(A_STATUS, q);
        chk("status_done", q, 32'h2);
        chk("glitch_55", mon_glitch, 0);
        chk("frame_err_55", mon_ferr, 0);

        // Overflow: six back-to-back pushes into a 4-deep FIFO
        rx_q.delete();
        exp6[0] = 8'h11; exp6[1] = 8'h22; exp6[2] = 8'h33;
        exp6[3] = 8'h44; exp6[4] = 8'h55; exp6[5] = 8'h66;
        for (int i = 0; i < 6; i++) begin
            wr(A_TXDATA, {24'd0, exp6[i]}, 4'b0001);
        end
        rd(A_STATUS, q);
        chk("status_ovf", q, 32'hD);
        wr(A_STATUS, 32'h0000_0008, 4'b0001);
        rd(A_STATUS, q);
        chk("status_ovf_clr", q, 32'h5);
        wait_rx(5, 400);
        for (int i = 0; i < 5; i++) begin
            chk_rx($sformatf("rx_burst%0d", i), exp6[i]);
        end
        repeat (60) @(negedge clk);
        chk("no_sixth", rx_q.size(), 0);
        chk("glitch_burst", mon_glitch, 0);

        // Paced stream wraps the pointers several times
        rx_q.delete();
        for (int i = 0; i < 20; i++) begin
            wr(A_TXDATA, 32'(8'(i * 13 + 7)), 4'b0001);
            repeat (44) @(negedge clk);
        end
        wait_rx(20, 200);
        for (int i = 0; i < 20; i++) begin
            chk_rx($sformatf("rx_wrap%0d", i), 8'(i * 13 + 7));
        end
        rd(A_STATUS, q);
        chk("status_wrap", q, 32'h2);
        chk("glitch_wrap", mon_glitch, 0);
        chk("frame_err_wrap", mon_ferr, 0);

        // Reset in the middle of a data bit
        rx_q.delete();
        rd(A_RAM, q);
        wr(A_TXDATA, 32'h0, 4'b0001);
        wr(A_TXDATA, 32'h0, 4'b0001);
        repeat (12) @(negedge clk);
        chk("pre_reset_tx", {31'd0, uart_tx}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("async_tx", {31'd0, uart_tx}, 32'd1);
        chk("async_q", dmem_q, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd(A_STATUS, q);
        chk("post_reset_status", q, 32'h2);
        repeat (100) @(negedge clk);
        chk("no_residual", rx_q.size(), 0);
        chk("idle_tx", {31'd0, uart_tx}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
